// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the 24-bit adder front end
// and the downstream normaliser.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 15;
    localparam int FP_BIAS   = 127;
    localparam int FP_MANT_W = FP_FRAC_W + 1;

    localparam logic [1:0] FP_OP_ADD = 2'b00;
    localparam logic [1:0] FP_OP_SUB = 2'b01;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp24_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W:0]   mant;
        logic                 eff_sub;
        logic [3:0]           opcode;
    } fp_align_rec_t;

    // Zero exponent flushes to a zero mantissa; otherwise restore the hidden 1.
    function automatic logic [FP_MANT_W-1:0] fp_unpack_mant(input fp24_t x);
        logic [FP_MANT_W-1:0] m;
        if (x.exp == '0) begin
            m = '0;
        end else begin
            m = {1'b1, x.frac};
        end
        return m;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Right shifter that aligns the smaller mantissa; shifts past the mantissa
// width saturate to zero (truncating, no guard/sticky).
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [FP_MANT_W-1:0] i_mant,
    input  logic [FP_EXP_W-1:0]  i_shift,
    output logic [FP_MANT_W-1:0] o_mant
);

    always_comb begin
        o_mant = '0;
        if (i_shift < 8'(FP_MANT_W)) begin
            o_mant = i_mant >> i_shift[3:0];
        end
    end

endmodule

// File: rtl/fp_addsub_align.sv
// Two-stage add/sub front end: order operands by magnitude, align the smaller
// mantissa and produce an unnormalised record for the normaliser.
module fp_addsub_align
    import fp_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    in_a_i,
    input  logic [WIDTH-1:0]    in_b_i,
    input  logic [3:0]          in_opcode_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_sign_o,
    output logic [FP_EXP_W-1:0] out_exp_o,
    output logic [FP_MANT_W:0]  out_mant_o,
    output logic                out_eff_sub_o,
    output logic [3:0]          out_opcode_o
);

    // Null ops zero the record; a zero magnitude is canonicalised to +0.
    function automatic fp_align_rec_t make_rec(
        input logic                sign_in,
        input logic [FP_EXP_W-1:0] exp_in,
        input logic [FP_MANT_W:0]  mant_in,
        input logic                eff_sub_in,
        input logic [3:0]          opcode_in
    );
        fp_align_rec_t rec;
        rec.sign    = sign_in;
        rec.exp     = exp_in;
        rec.mant    = mant_in;
        rec.eff_sub = eff_sub_in;
        rec.opcode  = opcode_in;
        if (opcode_in[1]) begin
            rec.sign    = 1'b0;
            rec.exp     = '0;
            rec.mant    = '0;
            rec.eff_sub = 1'b0;
        end else if (mant_in == '0) begin
            rec.sign = 1'b0;
            rec.exp  = '0;
        end
        return rec;
    endfunction

    fp24_t                w_a;
    fp24_t                w_b;
    logic [FP_MANT_W-1:0] w_mant_a;
    logic [FP_MANT_W-1:0] w_mant_b;
    logic                 w_sign_b;
    logic                 w_eff_sub;
    logic                 w_b_larger;
    logic                 w_s2_load;
    logic                 w_s1_adv;
    logic                 w_accept;

    logic                 r_vld_p1;
    logic                 r_sign_p1;
    logic [FP_EXP_W-1:0]  r_exp_p1;
    logic [FP_MANT_W-1:0] r_lmant_p1;
    logic [FP_MANT_W-1:0] r_smant_p1;
    logic [FP_EXP_W-1:0]  r_diff_p1;
    logic                 r_eff_sub_p1;
    logic [3:0]           r_opcode_p1;

    logic [FP_MANT_W-1:0] w_smant_aligned;
    logic [FP_MANT_W:0]   w_mant_res;
    fp_align_rec_t        w_rec_p2;

    logic                 r_vld_p2;
    fp_align_rec_t        r_rec_p2;

    assign w_s2_load  = !r_vld_p2 || out_ready_i;
    assign w_s1_adv   = r_vld_p1 && w_s2_load;
    assign in_ready_o = !rst_i && (!r_vld_p1 || w_s1_adv);
    assign w_accept   = in_valid_i && in_ready_o;

    assign w_a        = fp24_t'(in_a_i);
    assign w_b        = fp24_t'(in_b_i);
    assign w_mant_a   = fp_unpack_mant(w_a);
    assign w_mant_b   = fp_unpack_mant(w_b);
    assign w_sign_b   = w_b.sign ^ in_opcode_i[0];
    assign w_eff_sub  = w_a.sign ^ w_sign_b;
    assign w_b_larger = {w_b.exp, w_mant_b} > {w_a.exp, w_mant_a};

    // Stage 1: magnitude ordering and exponent difference
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            if (w_b_larger) begin
                r_sign_p1  <= w_sign_b;
                r_exp_p1   <= w_b.exp;
                r_lmant_p1 <= w_mant_b;
                r_smant_p1 <= w_mant_a;
                r_diff_p1  <= w_b.exp - w_a.exp;
            end else begin
                r_sign_p1  <= w_a.sign;
                r_exp_p1   <= w_a.exp;
                r_lmant_p1 <= w_mant_a;
                r_smant_p1 <= w_mant_b;
                r_diff_p1  <= w_a.exp - w_b.exp;
            end
            r_eff_sub_p1 <= w_eff_sub;
            r_opcode_p1  <= in_opcode_i;
        end
    end

    fp_align_shift u_align_shift (
        .i_mant  (r_smant_p1),
        .i_shift (r_diff_p1),
        .o_mant  (w_smant_aligned)
    );

    // L >= S by construction, so the subtraction never goes negative.
    assign w_mant_res = r_eff_sub_p1 ? ({1'b0, r_lmant_p1} - {1'b0, w_smant_aligned})
                                     : ({1'b0, r_lmant_p1} + {1'b0, w_smant_aligned});
    assign w_rec_p2   = make_rec(r_sign_p1, r_exp_p1, w_mant_res, r_eff_sub_p1, r_opcode_p1);

    // Stage 2: aligned add/sub result register and handshake state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_rec_p2 <= '0;
        end else begin
            if (w_accept) begin
                r_vld_p1 <= 1'b1;
            end else if (w_s1_adv) begin
                r_vld_p1 <= 1'b0;
            end
            if (w_s2_load) begin
                r_vld_p2 <= r_vld_p1;
            end
            if (w_s1_adv) begin
                r_rec_p2 <= w_rec_p2;
            end
        end
    end

    assign out_valid_o   = r_vld_p2;
    assign out_sign_o    = r_rec_p2.sign;
    assign out_exp_o     = r_rec_p2.exp;
    assign out_mant_o    = r_rec_p2.mant;
    assign out_eff_sub_o = r_rec_p2.eff_sub;
    assign out_opcode_o  = r_rec_p2.opcode;

endmodule
